// File: rtl/mul_rr_arbiter_rq_ack_pkg.sv
// rtl/mul_rr_arbiter_rq_ack_pkg.sv - shared types and constants for the multiplier arbiter
package mul_arb_pkg;

    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_ISSUE_ENC   = 2'd1;
    localparam logic [1:0] ST_RESPOND_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_ISSUE   = ST_ISSUE_ENC,
        ST_RESPOND = ST_RESPOND_ENC
    } arb_state_t;

    // Result returned to a master whose transaction was aborted; sliced to ACKDATA_WIDTH.
    localparam logic [63:0] TIMEOUT_RESULT = '1;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_rr_arbiter_rq_ack_rr_picker.sv
// rtl/mul_rr_arbiter_rq_ack_rr_picker.sv - combinational round-robin winner search from last+1
module rr_picker #(
    parameter int N  = 4,
    parameter int GW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last,
    output logic          valid,
    output logic [GW-1:0] winner
);

    logic [GW-1:0] idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 1; i <= N; i++) begin
            idx = GW'((int'(last) + i) % N);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/mul_rr_arbiter_rq_ack.sv
// rtl/mul_rr_arbiter_rq_ack.sv - round-robin arbiter sharing one req/ack multiplier slave
module mul_rr_arbiter_rq_ack
    import mul_arb_pkg::*;
#(
    parameter int NR_MASTERS    = 4,
    parameter int REQDATA_WIDTH = 16,
    parameter int ACKDATA_WIDTH = 16,
    parameter int TIMEOUT       = 64,
    localparam int GW           = clog2(NR_MASTERS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NR_MASTERS-1:0]               m_req,
    input  logic [NR_MASTERS*REQDATA_WIDTH-1:0] m_req_data,
    output logic [NR_MASTERS-1:0]               m_ack,
    output logic [ACKDATA_WIDTH-1:0]            m_ack_data,
    output logic                                s_req,
    output logic [REQDATA_WIDTH-1:0]            s_req_data,
    input  logic                                s_ack,
    input  logic [ACKDATA_WIDTH-1:0]            s_ack_data,
    output logic [GW-1:0]                       grant_id,
    output logic                                busy,
    output logic                                timeout_err
);

    localparam int CW = clog2(TIMEOUT + 2);

    arb_state_t                 state_q, state_d;
    logic                       s_req_q, s_req_d;
    logic [REQDATA_WIDTH-1:0]   s_req_data_q, s_req_data_d;
    logic [GW-1:0]              grant_id_q, grant_id_d;
    logic [GW-1:0]              last_q, last_d;
    logic [NR_MASTERS-1:0]      m_ack_q, m_ack_d;
    logic [ACKDATA_WIDTH-1:0]   m_ack_data_q, m_ack_data_d;
    logic                       timeout_err_q, timeout_err_d;
    logic [CW-1:0]              tcnt_q, tcnt_d;

    logic                       pick_valid;
    logic [GW-1:0]              pick_id;

    rr_picker #(
        .N  (NR_MASTERS),
        .GW (GW)
    ) u_picker (
        .req    (m_req),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_id)
    );

    always_comb begin
        state_d       = state_q;
        s_req_d       = s_req_q;
        s_req_data_d  = s_req_data_q;
        grant_id_d    = grant_id_q;
        last_d        = last_q;
        m_ack_d       = '0;
        m_ack_data_d  = m_ack_data_q;
        timeout_err_d = timeout_err_q;
        tcnt_d        = tcnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    for (int i = 0; i < NR_MASTERS; i++) begin
                        if (pick_id == GW'(i)) begin
                            s_req_data_d = m_req_data[i*REQDATA_WIDTH +: REQDATA_WIDTH];
                        end
                    end
                    grant_id_d = pick_id;
                    last_d     = pick_id;
                    s_req_d    = 1'b1;
                    tcnt_d     = '0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tcnt_d = tcnt_q + 1'b1;
                // A late s_ack on the limit cycle still wins over the abort.
                if (s_ack) begin
                    m_ack_data_d = s_ack_data;
                    s_req_d      = 1'b0;
                    m_ack_d      = NR_MASTERS'(1) << grant_id_q;
                    state_d      = ST_RESPOND;
                end else if (TIMEOUT > 0 && tcnt_q == CW'(TIMEOUT - 1)) begin
                    m_ack_data_d  = TIMEOUT_RESULT[ACKDATA_WIDTH-1:0];
                    s_req_d       = 1'b0;
                    timeout_err_d = 1'b1;
                    m_ack_d       = NR_MASTERS'(1) << grant_id_q;
                    state_d       = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                s_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            s_req_q       <= 1'b0;
            s_req_data_q  <= '0;
            grant_id_q    <= '0;
            last_q        <= GW'(NR_MASTERS - 1);
            m_ack_q       <= '0;
            m_ack_data_q  <= '0;
            timeout_err_q <= 1'b0;
            tcnt_q        <= '0;
        end else begin
            state_q       <= state_d;
            s_req_q       <= s_req_d;
            s_req_data_q  <= s_req_data_d;
            grant_id_q    <= grant_id_d;
            last_q        <= last_d;
            m_ack_q       <= m_ack_d;
            m_ack_data_q  <= m_ack_data_d;
            timeout_err_q <= timeout_err_d;
            tcnt_q        <= tcnt_d;
        end
    end

    assign m_ack       = m_ack_q;
    assign m_ack_data  = m_ack_data_q;
    assign s_req       = s_req_q;
    assign s_req_data  = s_req_data_q;
    assign grant_id    = grant_id_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mul_rr_arbiter_rq_ack.sv
// tb/tb_mul_rr_arbiter_rq_ack.sv - directed self-checking bench for the multiplier arbiter
module tb_mul_rr_arbiter_rq_ack;

    localparam int N  = 4;
    localparam int RW = 16;
    localparam int AW = 16;
    localparam int TO = 8;

    logic            clk;
    logic            rst;
    logic [N-1:0]    m_req;
    logic [N*RW-1:0] m_req_data;
    logic [N-1:0]    m_ack;
    logic [AW-1:0]   m_ack_data;
    logic            s_req;
    logic [RW-1:0]   s_req_data;
    logic            s_ack;
    logic [AW-1:0]   s_ack_data;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout_err;

    int errors;
    int checks;

    logic [RW-1:0] mdata [N];

    mul_rr_arbiter_rq_ack #(
        .NR_MASTERS    (N),
        .REQDATA_WIDTH (RW),
        .ACKDATA_WIDTH (AW),
        .TIMEOUT       (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_req       (m_req),
        .m_req_data  (m_req_data),
        .m_ack       (m_ack),
        .m_ack_data  (m_ack_data),
        .s_req       (s_req),
        .s_req_data  (s_req_data),
        .s_ack       (s_ack),
        .s_ack_data  (s_ack_data),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst        = 1'b1;
        m_req      = '0;
        s_ack      = 1'b0;
        s_ack_data = '0;
        mdata[0] = 16'h0011;
        mdata[1] = 16'h0305;
        mdata[2] = 16'h2233;
        mdata[3] = 16'h3344;
        m_req_data = {mdata[3], mdata[2], mdata[1], mdata[0]};
        @(negedge clk);
        step();
        step();
        rst = 1'b0;

        chk("rst_s_req", 32'(s_req), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_m_ack", 32'(m_ack), 32'h0);
        chk("rst_grant", 32'(grant_id), 32'h0);
        chk("rst_terr", 32'(timeout_err), 32'h0);
        chk("rst_ackdata", 32'(m_ack_data), 32'h0);

        // Single master 1, slave acks after 6 ISSUE cycles
        m_req = 4'b0010;
        step();
        chk("t1_s_req_rise", 32'(s_req), 32'h1);
        chk("t1_grant", 32'(grant_id), 32'h1);
        chk("t1_s_req_data", 32'(s_req_data), 32'h0305);
        chk("t1_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 5; i++) step();
        chk("t1_s_req_hold", 32'(s_req), 32'h1);
        chk("t1_no_ack_yet", 32'(m_ack), 32'h0);
        s_ack = 1'b1;
        s_ack_data = 16'h000F;
        step();
        s_ack = 1'b0;
        s_ack_data = 16'h1234;
        m_req = 4'b0000;
        chk("t1_m_ack", 32'(m_ack), 32'h2);
        chk("t1_ack_data", 32'(m_ack_data), 32'h000F);
        chk("t1_s_req_drop", 32'(s_req), 32'h0);
        step();
        chk("t1_ack_pulse_end", 32'(m_ack), 32'h0);
        chk("t1_ack_data_hold", 32'(m_ack_data), 32'h000F);
        chk("t1_idle", 32'(busy), 32'h0);

        // Fairness: all masters continuously requesting, from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t2_s_req", 32'(s_req), 32'h1);
            chk("t2_grant", 32'(grant_id), 32'(k % 4));
            chk("t2_s_req_data", 32'(s_req_data), 32'(mdata[k % 4]));
            step();
            s_ack = 1'b1;
            s_ack_data = 16'(16'h0100 + k);
            step();
            s_ack = 1'b0;
            chk("t2_m_ack", 32'(m_ack), 32'(4'b0001 << (k % 4)));
            chk("t2_ack_data", 32'(m_ack_data), 32'(16'h0100 + k));
            chk("t2_gap1", 32'(s_req), 32'h0);
            step();
            chk("t2_gap2", 32'(s_req), 32'h0);
            chk("t2_ack_clear", 32'(m_ack), 32'h0);
        end
        m_req = 4'b0000;
        step();

        // Master 2 drops its request during ISSUE
        m_req = 4'b0100;
        step();
        chk("t3_grant", 32'(grant_id), 32'h2);
        chk("t3_s_req_data", 32'(s_req_data), 32'h2233);
        m_req = 4'b0000;
        step();
        chk("t3_s_req_kept", 32'(s_req), 32'h1);
        chk("t3_no_early_ack", 32'(m_ack), 32'h0);
        s_ack = 1'b1;
        s_ack_data = 16'h0ABC;
        step();
        s_ack = 1'b0;
        chk("t3_m_ack", 32'(m_ack), 32'h4);
        chk("t3_ack_data", 32'(m_ack_data), 32'h0ABC);
        step();
        chk("t3_ack_clear", 32'(m_ack), 32'h0);
        chk("t3_terr", 32'(timeout_err), 32'h0);

        // Timeout: master 3, slave silent
        m_req = 4'b1000;
        step();
        chk("t4_grant", 32'(grant_id), 32'h3);
        m_req = 4'b0000;
        for (int i = 0; i < 7; i++) step();
        chk("t4_s_req_8th", 32'(s_req), 32'h1);
        chk("t4_terr_before", 32'(timeout_err), 32'h0);
        step();
        chk("t4_s_req_drop", 32'(s_req), 32'h0);
        chk("t4_m_ack", 32'(m_ack), 32'h8);
        chk("t4_ack_data", 32'(m_ack_data), 32'hFFFF);
        chk("t4_terr", 32'(timeout_err), 32'h1);
        step();
        chk("t4_ack_clear", 32'(m_ack), 32'h0);
        m_req = 4'b0001;
        step();
        chk("t4_good_grant", 32'(grant_id), 32'h0);
        m_req = 4'b0000;
        s_ack = 1'b1;
        s_ack_data = 16'h0042;
        step();
        s_ack = 1'b0;
        chk("t4_good_ack", 32'(m_ack), 32'h1);
        chk("t4_good_data", 32'(m_ack_data), 32'h0042);
        chk("t4_terr_sticky", 32'(timeout_err), 32'h1);
        step();

        // Reset during ISSUE
        mdata[0] = 16'h0707;
        m_req_data = {mdata[3], mdata[2], mdata[1], mdata[0]};
        m_req = 4'b0001;
        step();
        chk("t5_s_req", 32'(s_req), 32'h1);
        chk("t5_s_req_data", 32'(s_req_data), 32'h0707);
        step();
        rst = 1'b1;
        m_req = 4'b0011;
        step();
        chk("t5_rst_s_req", 32'(s_req), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        chk("t5_rst_m_ack", 32'(m_ack), 32'h0);
        chk("t5_rst_terr", 32'(timeout_err), 32'h0);
        rst = 1'b0;
        step();
        chk("t5_regrant", 32'(grant_id), 32'h0);
        chk("t5_regrant_data", 32'(s_req_data), 32'h0707);
        m_req = 4'b0000;

        // s_ack arriving on the timeout-limit cycle
        for (int i = 0; i < 7; i++) step();
        chk("t6_s_req_8th", 32'(s_req), 32'h1);
        s_ack = 1'b1;
        s_ack_data = 16'h0031;
        step();
        s_ack = 1'b0;
        chk("t6_m_ack", 32'(m_ack), 32'h1);
        chk("t6_ack_data", 32'(m_ack_data), 32'h0031);
        chk("t6_terr", 32'(timeout_err), 32'h0);
        step();
        chk("t6_ack_clear", 32'(m_ack), 32'h0);
        chk("t6_idle", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
